// File: rtl/onehot0_rr_arbiter.sv
// onehot0_rr_arbiter
// ------------------
// Round-robin arbiter that grants at most one of N requesters at a time.
// The grant is registered and is always one-hot-or-zero. Every grant ends
// with at least one all-zero cycle, so ownership never moves directly from
// one requester to another.
//
// Parameters:
//   N        number of requesters (2..16)
//   MAX_HOLD maximum consecutive grant cycles per owner (1..255)
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   req      [N-1:0]          request vector
//   gnt      [N-1:0]          registered grant vector, one-hot-or-zero
//   gnt_idx  [$clog2(N)-1:0]  index of the current owner, 0 when idle
//   busy                      high while gnt is nonzero
//
// Optional build macro: ONEHOT0_ARB_CHECK_EN compiles in concurrent
// assertions on the grant vector (onehot0, grant backed by request, busy
// consistency). Ports and behaviour do not change.

`ifdef ONEHOT0_ARB_CHECK_EN
module onehot0_rr_arbiter_checker #(
    parameter int N = 4
) (
    input logic         clk,
    input logic         rst_n,
    input logic [N-1:0] req,
    input logic [N-1:0] gnt,
    input logic         busy
);
    a_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt))
        else $error("%0t onehot0 violated gnt=%b", $time, gnt);

    a_busy: assert property (@(posedge clk) disable iff (!rst_n) busy == (gnt != '0))
        else $error("%0t busy disagrees with gnt=%b", $time, gnt);

    for (genvar i = 0; i < N; i++) begin : g_req_chk
        a_backed: assert property (@(posedge clk) disable iff (!rst_n)
                                   gnt[i] |-> ($past(req[i]) || !$past(gnt[i])))
            else $error("%0t grant %0d without request gnt=%b", $time, i, gnt);
    end
endmodule
`endif

module onehot0_rr_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 busy
);
    localparam int IW = $clog2(N);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Returns {valid, index} of the first set request at or after p, wrapping.
    function automatic logic [IW:0] rr_pick(input logic [N-1:0] r, input logic [IW-1:0] p);
        logic [2*N-1:0] rot;
        logic [IW:0]    sum;
        logic [IW:0]    res;
        rot = {r, r} >> p;
        res = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, p} + (IW+1)'(k);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end else begin
                sum = sum;
            end
            if (!res[IW] && rot[k]) begin
                res = {1'b1, sum[IW-1:0]};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    state_t        state_r, state_s;
    logic [IW-1:0] ptr_r, ptr_s;
    logic [IW-1:0] owner_r, owner_s;
    logic [7:0]    hold_cnt_r, hold_cnt_s;
    logic [N-1:0]  gnt_r, gnt_s;
    logic [IW-1:0] gnt_idx_r, gnt_idx_s;
    logic          busy_r, busy_s;
    logic [IW:0]   pick_s;

    // Arbitration result for the current pointer; only consumed in IDLE.
    always_comb begin
        pick_s = rr_pick(req, ptr_r);
    end

    // Next-state and next-output logic of the IDLE/GRANT machine.
    always_comb begin
        state_s    = state_r;
        ptr_s      = ptr_r;
        owner_s    = owner_r;
        hold_cnt_s = hold_cnt_r;
        gnt_s      = gnt_r;
        gnt_idx_s  = gnt_idx_r;
        busy_s     = busy_r;
        case (state_r)
            IDLE: begin
                if (pick_s[IW]) begin
                    owner_s    = pick_s[IW-1:0];
                    gnt_s      = {{(N-1){1'b0}}, 1'b1} << pick_s[IW-1:0];
                    gnt_idx_s  = pick_s[IW-1:0];
                    busy_s     = 1'b1;
                    hold_cnt_s = 8'd0;
                    state_s    = GRANT;
                end else begin
                    gnt_s     = '0;
                    gnt_idx_s = '0;
                    busy_s    = 1'b0;
                end
            end
            GRANT: begin
                if (req[owner_r] && (hold_cnt_r < 8'(MAX_HOLD - 1))) begin
                    hold_cnt_s = hold_cnt_r + 8'd1;
                end else begin
                    // Release always passes through an all-zero gap cycle.
                    gnt_s      = '0;
                    gnt_idx_s  = '0;
                    busy_s     = 1'b0;
                    hold_cnt_s = 8'd0;
                    state_s    = IDLE;
                    if (owner_r == IW'(N - 1)) begin
                        ptr_s = '0;
                    end else begin
                        ptr_s = owner_r + IW'(1);
                    end
                end
            end
            default: begin
                state_s    = IDLE;
                gnt_s      = '0;
                gnt_idx_s  = '0;
                busy_s     = 1'b0;
                hold_cnt_s = 8'd0;
            end
        endcase
    end

    // State, pointer and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            ptr_r      <= '0;
            owner_r    <= '0;
            hold_cnt_r <= 8'd0;
            gnt_r      <= '0;
            gnt_idx_r  <= '0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            ptr_r      <= ptr_s;
            owner_r    <= owner_s;
            hold_cnt_r <= hold_cnt_s;
            gnt_r      <= gnt_s;
            gnt_idx_r  <= gnt_idx_s;
            busy_r     <= busy_s;
        end
    end

    assign gnt     = gnt_r;
    assign gnt_idx = gnt_idx_r;
    assign busy    = busy_r;

`ifdef ONEHOT0_ARB_CHECK_EN
    onehot0_rr_arbiter_checker #(.N(N)) u_checker (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .gnt   (gnt_r),
        .busy  (busy_r)
    );
`else
    // Checks not compiled in this build.
`endif

endmodule

// File: doc/onehot0_rr_arbiter.md
# onehot0_rr_arbiter

Round-robin arbiter that grants at most one of N requesters at a time. The `gnt` vector is registered and is guaranteed one-hot-or-zero on every rising clock edge. It is the producer side of the `$onehot0` property that our assertion benches check. It sits between shared-resource requesters (bus masters, FIFO readers) and the resource mux, and drives the mux select directly.

## Interface
- `N`, default 4: number of requesters; legal range 2..16.
- `MAX_HOLD`, default 4: maximum consecutive cycles one owner may hold the grant; legal range 1..255.
- `clk`  in  1: the single clock; all logic is clocked on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `req`  in  N: request vector; bit i high means requester i wants the resource; may change on any cycle.
- `gnt`  out  N: registered grant vector, onehot0.
- `gnt_idx`  out  $clog2(N): index of the current owner; 0 when `gnt` is 0.
- `busy`  out  1: high when `gnt` is nonzero.

## Operation
- The arbiter is a two-state FSM, IDLE and GRANT, with these registers:
  - `ptr`: round-robin priority pointer, $clog2(N) bits.
  - `owner`: current owner index.
  - `hold_cnt`: 8 bits.
- **IDLE**
  - If `req` is nonzero, select the first set bit scanning from `ptr` upward and wrapping modulo N.
  - Then set `owner` to that index, set `gnt` to 1<<owner, clear `hold_cnt` to 0, and go to GRANT.
  - If `req` is 0, stay in IDLE with `gnt` held at 0.
- **GRANT**
  - If `req[owner]` is high and `hold_cnt` < MAX_HOLD-1, keep `gnt` unchanged and increment `hold_cnt`.
  - Otherwise (the owner dropped its request, or the hold limit was reached):
    - set `gnt` to 0 and `hold_cnt` to 0;
    - set `ptr` to (owner+1) mod N;
    - go to IDLE.
- **Gap cycle:** every grant ends with at least one cycle of `gnt` = 0. Ownership never transfers directly from one requester to another, so no two grant bits are ever high on the same edge or on adjacent edges.
- Requests from non-owners are ignored while in GRANT. Fairness comes from `ptr` advancing past the last owner.
- If `req[owner]` is still high when the hold limit expires, it competes normally in IDLE. It wins only if no other requester sits between `ptr` and it.
- `gnt_idx` and `busy` are registered alongside `gnt` and always agree with it.

## Timing
- **Reset values:** asynchronously on `rst_n` low, `gnt`=0, `gnt_idx`=0, `busy`=0, `ptr`=0, `hold_cnt`=0, and the FSM goes to IDLE.
- **Latency:**
  - A request sampled at edge k while in IDLE produces `gnt` visible after edge k (registered, 1 cycle).
  - A request drop sampled at edge k while in GRANT produces `gnt`=0 after edge k.
- **Hold limit:** a continuously requesting owner holds `gnt` for exactly MAX_HOLD cycles, then gets 1 gap cycle. With MAX_HOLD=1, grants alternate grant/gap.
- **Simultaneous requests in IDLE:** only the winner chosen by `ptr` is granted; `req` = all ones never produces more than one `gnt` bit.
- **Wrap-around:** with `ptr`=N-1, a request on bit 0 alone is granted.
- **Reset mid-grant:** `gnt` clears immediately (asynchronously); after release, arbitration restarts from `ptr`=0.
- **Minimum re-grant spacing:** any requester that loses the grant waits at least 1 cycle before it can be granted again.

## Configuration
- `ONEHOT0_ARB_CHECK_EN`
  - **Defined:** the block compiles in concurrent assertions, all disabled while `rst_n` is low. Each failure reports `$error` with the time and the `gnt` value. The assertions are:
    - `@(posedge clk)` `$onehot0(gnt)`;
    - `gnt[i]` implies `$past(req[i])` held high, or the grant is in its first cycle;
    - `busy` == (`gnt` != 0).
  - **Undefined:** no assertion code is compiled.
  - Ports and functional behaviour are identical in both cases.

## Test plan
- **Reset check:** with N=4 and MAX_HOLD=4, drive `req`=4'b1111 during reset, then release → `gnt` is 0 during reset. After release, the sequence is `gnt`=0001 for 4 cycles, 0000, 0010 for 4 cycles, 0000, 0100, …; `gnt` is never non-onehot0.
- **Owner drops early:** `req`=0100 for 2 cycles, then 0000 → `gnt`=0100 for 2 cycles, then 0000; `ptr` becomes 3.
- **Wrap-around:** with `ptr`=3 (after granting bit 2), drive `req`=0001 → `gnt`=0001, `gnt_idx`=0.
- **Non-owner ignored:** while bit 1 is granted, raise `req[3]` → `gnt` stays 0010 until bit 1 drops or hits the hold limit. After the gap cycle, `gnt`=1000.
- **Async reset mid-grant:** assert `rst_n` low mid-cycle during a grant → `gnt`, `busy` and `gnt_idx` go to 0 before the next edge. After release with `req`=1000, `gnt`=1000 one cycle later.
- **Random check:** run 10k cycles of random `req` with `ONEHOT0_ARB_CHECK_EN` defined → zero assertion failures, and every requester is granted within N×(MAX_HOLD+1) cycles of raising a continuous request.
